axis_crc32_append: RTL

Byte-wide AXI4-Stream stage that forwards every frame unchanged and appends the frame's 4-byte CRC-32 (Ethernet/zlib variant) after the last data byte, moving TLAST onto the final CRC byte. It sits in `design_1` between the AXI4-Stream VIP master (upstream) and the passthrough monitor and slave VIP (downstream). It is the CRC producer whose output the downstream checker and VIP slave consume.

---
 rtl/crc_pkg.sv | 25 ++
 rtl/crc32_byte.sv | 16 +
 rtl/axis_crc32_append.sv | 122 ++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared CRC-32 (reflected, Ethernet/zlib) constants, state type and byte-update function.
// Used by the append stage and by the downstream checker.
package crc_pkg;

  localparam logic [31:0] CRC32_REV_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT   = 32'hFFFFFFFF;

  typedef enum logic {
    DATA = 1'b0,
    CRC  = 1'b1
  } crc_state_t;

  // Reflected byte-wise update: fold the byte into the low bits, then shift out 8 times.
  function automatic logic [31:0] crc32_byte_next(logic [31:0] crc, logic [7:0] d,
                                                  logic [31:0] poly = CRC32_REV_POLY);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ poly) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte CRC-32 update around the package function.
module crc32_byte
  import crc_pkg::*;
#(
  parameter logic [31:0] REV_POLY = CRC32_REV_POLY
) (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc32_byte_next(crc_in, data, REV_POLY);
  end

endmodule

// File: rtl/axis_crc32_append.sv
// Byte-wide AXI4-Stream stage: forwards each frame and appends its CRC-32, LSB byte first,
// with TLAST moved onto the final CRC byte.
module axis_crc32_append
  import crc_pkg::*;
#(
  parameter logic [31:0] REV_POLY   = CRC32_REV_POLY,
  parameter logic [31:0] CRC_INIT   = CRC32_INIT,
  parameter logic [31:0] CRC_XOROUT = CRC32_XOROUT
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [31:0] crc_value,
  output logic        crc_done
);

  // Handshake: a beat transfers on a rising edge where tvalid && tready; the output
  // register holds tdata/tlast stable while tvalid is high and tready is low, and
  // tvalid never depends combinationally on tready.

  crc_state_t  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_nxt;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [31:0] crc_value_q, crc_value_d;
  logic        done_q, done_d;
  logic        load_en;
  logic        s_hs;

  crc32_byte #(
    .REV_POLY(REV_POLY)
  ) u_crc32_byte (
    .crc_in (crc_q),
    .data   (s_axis_tdata),
    .crc_out(crc_nxt)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    crc_d         = crc_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    crc_value_d   = crc_value_q;
    done_d        = 1'b0;
    load_en       = !tvalid_q || m_axis_tready;
    s_axis_tready = (state_q == DATA) && load_en;
    s_hs          = s_axis_tvalid && s_axis_tready;

    case (state_q)
      DATA: begin
        if (s_hs) begin
          tdata_d  = s_axis_tdata;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          crc_d    = crc_nxt;
          if (s_axis_tlast) begin
            crc_value_d = crc_nxt ^ CRC_XOROUT;
            done_d      = 1'b1;
            idx_d       = 2'd0;
            state_d     = CRC;
          end
        end else if (load_en) begin
          tvalid_d = 1'b0;
        end
      end
      CRC: begin
        if (load_en) begin
          tdata_d  = crc_value_q[{idx_q, 3'b000} +: 8];
          tvalid_d = 1'b1;
          tlast_d  = (idx_q == 2'd3);
          idx_d    = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DATA;
            crc_d   = CRC_INIT;
          end
        end
      end
      default: state_d = DATA;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= DATA;
      idx_q       <= 2'd0;
      crc_q       <= CRC_INIT;
      tdata_q     <= 8'h00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      crc_value_q <= 32'h0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      crc_q       <= crc_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      crc_value_q <= crc_value_d;
      done_q      <= done_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign crc_value     = crc_value_q;
  assign crc_done      = done_q;

endmodule
